// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one at a time in index order, each release gated by the previous domain's ack.
module rst_seq_ctrl #(
    parameter int NDOMAINS   = 4,
    parameter int HOLDCYCLES = 4,
    parameter int STAGEDELAY = 8,
    parameter int ACKTIMEOUT = 64,
    localparam int IDXW      = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                sw_rst_req,
    input  logic [NDOMAINS-1:0] dom_ready,
    output logic [NDOMAINS-1:0] dom_reset,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [IDXW-1:0]     fault_dom
);

    localparam int MAXC_HD = (HOLDCYCLES > STAGEDELAY) ? HOLDCYCLES : STAGEDELAY;
    localparam int MAXC    = (MAXC_HD > ACKTIMEOUT) ? MAXC_HD : ACKTIMEOUT;
    localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLDCYCLES - 1);
    localparam logic [CW-1:0]   DELAY_LAST = CW'(STAGEDELAY - 1);
    localparam logic [CW-1:0]   ACK_LAST   = CW'(ACKTIMEOUT - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NDOMAINS - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_DELAY,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IDXW-1:0]     idx_reg, idx_next;
    logic [NDOMAINS-1:0] dom_reset_reg, dom_reset_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                fault_reg, fault_next;
    logic [IDXW-1:0]     fault_dom_reg, fault_dom_next;
    logic                ready_cur;
    logic                restart;

    // Only the domain currently being waited on can acknowledge.
    assign ready_cur = dom_ready[idx_reg];
    assign restart   = hold | sw_rst_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_ASSERT;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            dom_reset_reg <= '1;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            fault_dom_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            dom_reset_reg <= dom_reset_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            fault_dom_reg <= fault_dom_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (hold) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
        end else if (sw_rst_req) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = ST_DELAY;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt_reg == DELAY_LAST) begin
                        state_next = ST_WAIT_ACK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack on the timeout edge still counts as an ack.
                    if (ready_cur) begin
                        if (idx_reg == IDX_LAST) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_DELAY;
                            idx_next   = idx_reg + 1'b1;
                            cnt_next   = '0;
                        end
                    end else if (cnt_reg == ACK_LAST) begin
                        state_next = ST_FAULT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dom_reset_next = dom_reset_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        fault_next     = fault_reg;
        fault_dom_next = fault_dom_reg;
        if (restart) begin
            dom_reset_next = '1;
            busy_next      = 1'b1;
            done_next      = 1'b0;
            fault_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_ASSERT: dom_reset_next = '1;
                ST_DELAY: begin
                    if (cnt_reg == DELAY_LAST) dom_reset_next[idx_reg] = 1'b0;
                end
                ST_WAIT_ACK: begin
                    if (ready_cur) begin
                        if (idx_reg == IDX_LAST) begin
                            done_next = 1'b1;
                            busy_next = 1'b0;
                        end
                    end else if (cnt_reg == ACK_LAST) begin
                        fault_next     = 1'b1;
                        fault_dom_next = idx_reg;
                        busy_next      = 1'b0;
                        dom_reset_next = '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dom_reset = dom_reset_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fault     = fault_reg;
    assign fault_dom = fault_dom_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a release-count/timer reference model.
module tb_rst_seq_ctrl;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int DLY  = 8;
    localparam int TO   = 64;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          hold = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic [N-1:0]  dom_ready = '0;
    logic [N-1:0]  dom_reset;
    logic          busy;
    logic          done;
    logic          fault;
    logic [IW-1:0] fault_dom;

    int tests_run    = 0;
    int tests_failed = 0;

    rst_seq_ctrl #(
        .NDOMAINS  (N),
        .HOLDCYCLES(HOLD),
        .STAGEDELAY(DLY),
        .ACKTIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .sw_rst_req(sw_rst_req),
        .dom_ready (dom_ready),
        .dom_reset (dom_reset),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fault_dom (fault_dom)
    );

    always #5 clk = ~clk;

    // Reference model: how many domains are released / acknowledged, and how
    // many edges have elapsed in the current wait.
    int m_since = 0;
    int m_nrel  = 0;
    int m_acked = 0;
    bit m_fault = 0;
    bit m_fin   = 0;
    int m_fdom  = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_since = 0; m_nrel = 0; m_acked = 0; m_fault = 0; m_fin = 0; m_fdom = 0;
        end else if (hold || sw_rst_req) begin
            m_since = 0; m_nrel = 0; m_acked = 0; m_fault = 0; m_fin = 0;
        end else if (m_fault || m_fin) begin
            m_since = m_since;
        end else if (m_nrel == m_acked) begin
            m_since++;
            if (m_since == ((m_acked == 0) ? HOLD + DLY : DLY)) begin
                m_nrel++;
                m_since = 0;
            end
        end else begin
            if (dom_ready[m_acked]) begin
                m_acked++;
                m_since = 0;
                if (m_acked == N) m_fin = 1;
            end else begin
                m_since++;
                if (m_since == TO) begin
                    m_fault = 1;
                    m_fdom  = m_acked;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] exp_rst;
        for (int b = 0; b < N; b++) exp_rst[b] = m_fault ? 1'b1 : (b >= m_nrel);
        chk("dom_reset", 32'(dom_reset), 32'(exp_rst));
        chk("busy", 32'(busy), 32'(!m_fault && !m_fin));
        chk("done", 32'(done), 32'(m_fin));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_dom", 32'(fault_dom), 32'(m_fdom));
    endtask

    // Drive inputs for one edge, then compare against the model just after it.
    task automatic step(input logic r, input logic h, input logic s, input logic [N-1:0] rdy);
        reset      = r;
        hold       = h;
        sw_rst_req = s;
        dom_ready  = rdy;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Edges (counting from 1) until dom_reset[0] falls, with immediate acks.
    task automatic first_release(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1'b1, 1'b0, 1'b0, ~dom_reset);
            if (!dom_reset[0]) begin
                n = i;
                break;
            end
        end
        chk(tag, 32'(n), 32'(HOLD + DLY));
    endtask

    task automatic run_ack(input int n, input logic [N-1:0] msk);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, ~dom_reset & msk);
    endtask

    int fall_edge [N];

    initial begin
        // Nominal sequence: record the edge each domain is released on.
        do_reset();
        chk("reset_rst", 32'(dom_reset), 32'hf);
        chk("reset_busy", 32'(busy), 32'd1);
        for (int b = 0; b < N; b++) fall_edge[b] = 0;
        for (int e = 1; e <= 45; e++) begin
            logic [N-1:0] prev;
            prev = dom_reset;
            step(1'b1, 1'b0, 1'b0, ~dom_reset);
            for (int b = 0; b < N; b++)
                if (prev[b] && !dom_reset[b]) fall_edge[b] = e;
        end
        for (int b = 0; b < N; b++)
            chk($sformatf("fall_edge%0d", b), 32'(fall_edge[b]), 32'(HOLD + DLY + b * (DLY + 1)));
        chk("nom_done", 32'(done), 32'd1);
        $display("[TB] nominal: falls at %0d %0d %0d %0d", fall_edge[0], fall_edge[1], fall_edge[2], fall_edge[3]);

        // Ack timeout on domain 2.
        do_reset();
        run_ack(93, 4'b1011);
        chk("to_pre", 32'(fault), 32'd0);
        run_ack(1, 4'b1011);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_fdom", 32'(fault_dom), 32'd2);
        chk("to_rst", 32'(dom_reset), 32'hf);
        chk("to_busy", 32'(busy), 32'd0);
        run_ack(30, 4'b1011);
        $display("[TB] timeout: fault=%0d fault_dom=%0d", fault, fault_dom);

        // Ready arriving on the exact timeout edge is accepted.
        do_reset();
        run_ack(93, 4'b1011);
        run_ack(1, 4'b1111);
        chk("edge_ack_fault", 32'(fault), 32'd0);
        run_ack(12, 4'b1111);
        chk("edge_ack_done", 32'(done), 32'd1);
        $display("[TB] ack on timeout edge: done=%0d fault=%0d", done, fault);

        // Hold after reset, then hold again in DONE.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, ~dom_reset);
            chk("hold_rst", 32'(dom_reset), 32'hf);
        end
        first_release("hold_first_rel");
        run_ack(40, 4'b1111);
        step(1'b1, 1'b1, 1'b0, ~dom_reset);
        chk("hold_done_rst", 32'(dom_reset), 32'hf);
        chk("hold_done_done", 32'(done), 32'd0);
        $display("[TB] hold: dom_reset=%0h done=%0d", dom_reset, done);

        // Software restart from DONE, then mid-sequence in WAIT_ACK of domain 1.
        first_release("hold_rel2");
        run_ack(40, 4'b1111);
        step(1'b1, 1'b0, 1'b1, ~dom_reset);
        chk("sw_rst", 32'(dom_reset), 32'hf);
        chk("sw_done", 32'(done), 32'd0);
        chk("sw_busy", 32'(busy), 32'd1);
        first_release("sw_first_rel");
        run_ack(14, 4'b1101);
        chk("sw_mid_rel1", 32'(dom_reset), 32'hc);
        step(1'b1, 1'b0, 1'b1, ~dom_reset & 4'b1101);
        chk("sw_mid_rst", 32'(dom_reset), 32'hf);
        first_release("sw_mid_first_rel");
        $display("[TB] sw restart: busy=%0d", busy);

        // Reset during WAIT_ACK of domain 1.
        run_ack(14, 4'b1101);
        step(1'b0, 1'b0, 1'b0, ~dom_reset & 4'b1101);
        chk("rmid_rst", 32'(dom_reset), 32'hf);
        chk("rmid_busy", 32'(busy), 32'd1);
        chk("rmid_done", 32'(done), 32'd0);
        chk("rmid_fault", 32'(fault), 32'd0);
        chk("rmid_fdom", 32'(fault_dom), 32'd0);
        $display("[TB] reset mid-sequence: dom_reset=%0h", dom_reset);

        // Hold and sw request together while faulted: hold wins.
        do_reset();
        run_ack(110, 4'b1110);
        chk("ff_fault", 32'(fault), 32'd1);
        chk("ff_fdom", 32'(fault_dom), 32'd0);
        step(1'b1, 1'b1, 1'b1, ~dom_reset);
        chk("ff_clear", 32'(fault), 32'd0);
        chk("ff_rst", 32'(dom_reset), 32'hf);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, ~dom_reset);
        first_release("ff_first_rel");
        $display("[TB] hold+sw in fault: fault=%0d", fault);

        // Randomized traffic.
        begin
            logic [N-1:0] msk;
            logic [N-1:0] rdy;
            logic r, h, s;
            msk = '1;
            h   = 1'b0;
            do_reset();
            for (int i = 0; i < 5000; i++) begin
                if ($urandom_range(59) == 0) msk = N'($urandom);
                if ($urandom_range(79) == 0) h = ~h;
                r   = ($urandom_range(299) != 0);
                s   = ($urandom_range(149) == 0);
                rdy = N'($urandom) & msk;
                step(r, h, s, rdy);
            end
            $display("[TB] random: 5000 cycles done");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for simulation and SoC top levels. It takes one global reset and releases NDOMAINS downstream reset domains in a fixed order, from index 0 upward. Each release is separated by a programmable delay and gated by a per-domain ready acknowledge. A missing acknowledge raises a fault, and a software request restarts the whole sequence.

Parameters:
NDOMAINS, 4, number of sequenced reset domains (≥1)
HOLDCYCLES, 4, cycles all domains stay asserted after global reset/hold release (≥1)
STAGEDELAY, 8, cycles between a domain's ack (or end of hold) and the next release (≥1)
ACKTIMEOUT, 64, max cycles to wait for dom_ready after a release (≥1)
IDXW, max(1,$clog2(NDOMAINS)), domain index width (derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  global reset, synchronous, active-low (0 = reset)
hold  in  1  gate; while 1, all domains held in reset, sequence does not advance
sw_rst_req  in  1  single-cycle request to re-run the sequence
dom_ready  in  NDOMAINS  per-domain ready acknowledge
dom_reset  out  NDOMAINS  per-domain reset, active-high (1 = held in reset)
busy  out  1  sequence in progress
done  out  1  all domains released and acknowledged
fault  out  1  ack timeout occurred
fault_dom  out  IDXW  index of the domain that timed out

Behaviour:
- All outputs are registered. Reset is sampled on clk only.
- On reset=0: state=ASSERT, cnt=0, idx=0, dom_reset='1, busy=1, done=0, fault=0, fault_dom=0.
- Priority each edge: reset > hold > sw_rst_req > normal transition.
- hold=1 in any state:
  - next state ASSERT, cnt=0.
  - dom_reset='1, done=0, fault=0, busy=1.
- sw_rst_req=1 in any state with hold=0:
  - next state ASSERT, cnt=0, idx=0, dom_reset='1, done=0, fault=0, busy=1.
  - This includes a restart mid-sequence.
- ASSERT:
  - dom_reset='1.
  - Exit when cnt==HOLDCYCLES-1: go to DELAY, cnt=0, idx=0. Otherwise cnt++.
- DELAY:
  - Exit when cnt==STAGEDELAY-1: dom_reset[idx]<=0, go to WAIT_ACK, cnt=0. Otherwise cnt++.
- WAIT_ACK:
  - If dom_ready[idx]=1 sampled:
    - idx==NDOMAINS-1: go to DONE, done<=1, busy<=0.
    - Otherwise: idx++, go to DELAY, cnt=0.
  - Else if cnt==ACKTIMEOUT-1: go to FAULT, fault<=1, fault_dom<=idx, busy<=0, dom_reset<='1.
  - Else cnt++.
  - Ready wins over timeout on the same edge.
- DONE: holds all dom_reset=0, done=1. Exit only via hold, sw_rst_req or reset.
- FAULT: holds fault=1, dom_reset='1. Exit only via hold, sw_rst_req or reset.
- dom_ready bits of non-current domains are ignored. A released domain dropping ready does not re-trigger anything.
- A domain, once released, stays released until the next reset, hold, fault or sw_rst_req. Domains with a higher index are never released before lower ones.
- Release timing from the first edge with reset=1 and hold=0, counting that edge as 1: dom_reset[0] falls at edge HOLDCYCLES+STAGEDELAY.
- With immediate ready, each later domain falls STAGEDELAY+1 edges after the previous one.
- Counter width is sized for max(HOLDCYCLES,STAGEDELAY,ACKTIMEOUT)-1. Counters never wrap.

Test Plan:
- Nominal, defaults: reset=0 for 3 cycles then 1, hold=0, dom_ready=~dom_reset combinationally → dom_reset bits fall at edges 12, 21, 30, 39 in order 0..3; done=1 and busy=0 after edge 40; fault stays 0.
- Timeout: as nominal but dom_ready[2] tied 0 → dom_reset[2] falls at edge 30; at edge 94 fault=1, fault_dom=2, dom_reset=4'b1111, busy=0; dom_reset[3] never falls.
- Hold: hold=1 for 20 cycles after reset release → dom_reset=4'b1111 throughout; the first release occurs 12 edges after hold is first sampled 0. Assert hold=1 again in DONE → dom_reset=4'b1111 and done=0 on the next edge.
- Software restart: 1-cycle sw_rst_req in DONE → next edge dom_reset=4'b1111, done=0, busy=1; sequence repeats with identical spacing (first release 12 edges later). Repeat with a pulse during WAIT_ACK of domain 1 → restart from idx 0.
- Reset mid-sequence: reset=0 during WAIT_ACK of domain 1 → next edge all outputs at reset values (dom_reset=4'b1111, busy=1, done=0, fault=0, fault_dom=0).
- Simultaneous events in FAULT: hold=1 and sw_rst_req=1 on the same edge → hold wins, state ASSERT, fault clears; sequence resumes only after hold=0. Separately, dom_ready[idx] rising on the exact timeout edge (cnt=63) → domain accepted, no fault.
